mux_scan_sel: RTL

Parametrised, registered N-channel, W-bit channel selector with two operating modes. In manual mode a host-driven select picks the channel. In scan mode the block steps through the channels round-robin, dwelling a fixed number of cycles on each. It supersedes the fixed 4-bit 2:1 combinational mux array wherever a monitored or time-multiplexed data path needs a registered output and a channel tag.

---
 rtl/mux_scan_sel_if.sv | 29 ++
 rtl/mux_scan_sel.sv | 115 +++++++++++
 2 files changed

// File: rtl/mux_scan_sel_if.sv
// Bus bundle for mux_scan_sel: channel inputs, mode/select/hold controls and
// the registered output side (data, channel tag, status pulses).
// The host side (master) drives inputs and observes outputs; the selector
// (slave) does the opposite.
interface mux_scan_sel_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic                      mode;
  logic [SELW-1:0]           sel;
  logic                      hold;
  logic [WIDTH-1:0]          f;
  logic [SELW-1:0]           ch;
  logic                      valid;
  logic                      wrap;
  logic                      sel_err;

  modport master (
    output din, mode, sel, hold,
    input  f, ch, valid, wrap, sel_err
  );

  modport slave (
    input  din, mode, sel, hold,
    output f, ch, valid, wrap, sel_err
  );
endinterface

// File: rtl/mux_scan_sel.sv
// Registered N-channel selector. In manual mode the host select picks the
// channel; in scan mode the block walks the channels round-robin, dwelling
// DWELL cycles on each. The output data f and the channel tag ch are always
// captured together, so f is the data of channel ch sampled on the same edge.
module mux_scan_sel #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 8,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_scan_sel_if.slave bus
);

  // Dwell counter needs at least one bit even when DWELL=1.
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);
  localparam logic [SELW-1:0] LAST_CH    = SELW'(CHANNELS - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t            state;
  logic [CW-1:0]     dwell_cnt;
  logic [SELW-1:0]   cur_ch;
  logic [WIDTH-1:0]  f_data;
  logic              valid_flag;
  logic              wrap_flag;
  logic              err_flag;

  logic [SELW-1:0]   sel_eff;
  logic [CW-1:0]     cnt_next;
  logic              wrap_next;
  logic              err_next;
  logic              sel_ok;

  // Split the packed input bus into one word per channel.
  logic [WIDTH-1:0]  chan [CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan[gi] = bus.din[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // A manual select is usable only when it names an existing channel; with a
  // power-of-two channel count every encoding is valid.
  assign sel_ok = (int'(bus.sel) < CHANNELS);

  // Next channel, dwell count and event pulses. mode is acted on directly:
  // leaving scan applies sel on the same edge, while entering scan spends
  // the first edge clearing the dwell counter so the first SCAN cycle is
  // dwell cycle 0 of the channel already selected.
  always_comb begin
    sel_eff   = cur_ch;
    cnt_next  = dwell_cnt;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    if (!bus.mode) begin
      if (!bus.hold) begin
        if (sel_ok) begin
          sel_eff = bus.sel;
        end else begin
          err_next = 1'b1;
        end
      end
    end else if (state == MANUAL) begin
      cnt_next = '0;
    end else if (!bus.hold) begin
      if (dwell_cnt == DWELL_LAST) begin
        cnt_next = '0;
        if (cur_ch == LAST_CH) begin
          sel_eff   = '0;
          wrap_next = 1'b1;
        end else begin
          sel_eff = cur_ch + 1'b1;
        end
      end else begin
        cnt_next = dwell_cnt + 1'b1;
      end
    end
  end

  // Mode FSM with all outputs registered; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MANUAL;
      dwell_cnt  <= '0;
      cur_ch     <= '0;
      f_data     <= '0;
      valid_flag <= 1'b0;
      wrap_flag  <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      state      <= bus.mode ? SCAN : MANUAL;
      dwell_cnt  <= cnt_next;
      cur_ch     <= sel_eff;
      f_data     <= chan[sel_eff];
      valid_flag <= 1'b1;
      wrap_flag  <= wrap_next;
      err_flag   <= err_next;
    end
  end

  assign bus.f       = f_data;
  assign bus.ch      = cur_ch;
  assign bus.valid   = valid_flag;
  assign bus.wrap    = wrap_flag;
  assign bus.sel_err = err_flag;

endmodule
